vliw_fetch_ctrl: RTL and testbench

- Sequences the VLIW fetch stage: owns the program counter and fetches 64-bit bundles from instruction memory over a req/ack handshake.
- When a bundle contains a load slot, also fetches the 192-bit literal data word from data memory.
- Presents word/data to the fetch stage, and drives its flush input to insert NOP bundles whenever no valid bundle is being issued.
- Handles downstream stall and branch redirect.

---
 rtl/vliw_pkg.sv | 23 ++
 rtl/vliw_bundle_has_load.sv | 13 +
 rtl/vliw_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_vliw_fetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW fetch controller: bundle layout, opcodes and FSM encoding.
package vliw_pkg;

  localparam int BUNDLE_W = 64;
  localparam int LIT_W    = 192;
  localparam int OP_W     = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_LOAD = 4'b0100;

  // Opcode field LSB of each of the three issue slots.
  localparam int SLOT0_LSB = 55;
  localparam int SLOT1_LSB = 35;
  localparam int SLOT2_LSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DFETCH = 2'd2,
    ST_ISSUE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vliw_bundle_has_load.sv
// Flags a bundle in which any of the three slot opcodes is LOAD.
module vliw_bundle_has_load
  import vliw_pkg::*;
(
  input  logic [BUNDLE_W-1:0] bundle,
  output logic                has_load
);

  assign has_load = (bundle[SLOT0_LSB +: OP_W] == OP_LOAD)
                  | (bundle[SLOT1_LSB +: OP_W] == OP_LOAD)
                  | (bundle[SLOT2_LSB +: OP_W] == OP_LOAD);

endmodule

// File: rtl/vliw_fetch_ctrl.sv
// VLIW fetch sequencer: owns the PC, fetches bundles and literal data over req/ack,
// and drives NOP insertion (flush) whenever no valid bundle is issuing.
module vliw_fetch_ctrl
  import vliw_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [BUNDLE_W-1:0] imem_rdata,
  output logic                dmem_req,
  output logic [ADDR_W-1:0]   dmem_addr,
  input  logic                dmem_ack,
  input  logic [LIT_W-1:0]    dmem_rdata,
  output logic [BUNDLE_W-1:0] word,
  output logic [LIT_W-1:0]    data,
  output logic                flush,
  output logic [ADDR_W-1:0]   pc
);

  fetch_state_e      state, next_state;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_target;
  logic              has_load;
  logic              squash;

  vliw_bundle_has_load u_has_load (
    .bundle   (imem_rdata),
    .has_load (has_load)
  );

  // A transaction that completes while a redirect is live or pending is thrown away.
  assign squash = redirect | redir_pend;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      ST_IDLE:   if (run) next_state = ST_IFETCH;
      ST_IFETCH: if (imem_ack) begin
                   if (squash)        next_state = ST_IFETCH;
                   else if (has_load) next_state = ST_DFETCH;
                   else               next_state = ST_ISSUE;
                 end
      ST_DFETCH: if (dmem_ack) next_state = squash ? ST_IFETCH : ST_ISSUE;
      ST_ISSUE:  if (redirect || !stall) next_state = run ? ST_IFETCH : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_IFETCH);
    dmem_req  = (state == ST_DFETCH);
    flush     = (state != ST_ISSUE) | redirect | redir_pend;
    imem_addr = pc;
    dmem_addr = pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= RESET_PC;
      word         <= '0;
      data         <= '0;
      redir_pend   <= 1'b0;
      redir_target <= '0;
    end else begin
      case (state)
        ST_IDLE: if (redirect) pc <= redirect_pc;
        ST_IFETCH: begin
          if (imem_ack) begin
            redir_pend <= 1'b0;
            if (redirect)        pc <= redirect_pc;
            else if (redir_pend) pc <= redir_target;
            else begin
              word <= imem_rdata;
              if (!has_load) data <= '0;
            end
          end else if (redirect) begin
            redir_pend   <= 1'b1;
            redir_target <= redirect_pc;
          end
        end
        ST_DFETCH: begin
          if (dmem_ack) begin
            redir_pend <= 1'b0;
            if (redirect)        pc   <= redirect_pc;
            else if (redir_pend) pc   <= redir_target;
            else                 data <= dmem_rdata;
          end else if (redirect) begin
            redir_pend   <= 1'b1;
            redir_target <= redirect_pc;
          end
        end
        ST_ISSUE: begin
          if (redirect)    pc <= redirect_pc;
          else if (!stall) pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_fetch_ctrl.sv
// Directed bench for vliw_fetch_ctrl: per-cycle vector table plus hand sequences for load
// detection and reset during a literal fetch.
module tb_vliw_fetch_ctrl;
  import vliw_pkg::*;

  localparam int ADDR_W = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                run = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [ADDR_W-1:0]   redirect_pc = '0;
  logic                imem_req, dmem_req, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [ADDR_W-1:0]   imem_addr, dmem_addr, pc;
  logic [BUNDLE_W-1:0] imem_rdata = '0, word;
  logic [LIT_W-1:0]    dmem_rdata = '0, data;
  logic                flush;

  int checks = 0;
  int failures = 0;

  vliw_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .run(run), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .word(word), .data(data), .flush(flush), .pc(pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, run, stall, redir;
    logic [ADDR_W-1:0] rpc;
    logic iack;
    logic [BUNDLE_W-1:0] idat;
    logic dack;
    logic [LIT_W-1:0] ddat;
    logic chk;
    logic ireq, dreq, flush;
    logic [ADDR_W-1:0] pc;
    logic [BUNDLE_W-1:0] word;
    logic [LIT_W-1:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input logic rst, run, stall, redir, input logic [ADDR_W-1:0] rpc,
      input logic iack, input logic [BUNDLE_W-1:0] idat,
      input logic dack, input logic [LIT_W-1:0] ddat,
      input logic chk, input logic ireq, dreq, fl,
      input logic [ADDR_W-1:0] epc, input logic [BUNDLE_W-1:0] ew, input logic [LIT_W-1:0] ed);
    vec_t v;
    v.rst = rst; v.run = run; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.iack = iack; v.idat = idat; v.dack = dack; v.ddat = ddat; v.chk = chk;
    v.ireq = ireq; v.dreq = dreq; v.flush = fl; v.pc = epc; v.word = ew; v.data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [LIT_W-1:0] act, input logic [LIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  localparam logic [BUNDLE_W-1:0] LW = 64'h0000_0020_0000_00AB;  // LOAD in slot [38:35]
  localparam logic [LIT_W-1:0]    A5 = {24{8'hA5}};

  logic [BUNDLE_W-1:0] lw_tbl [4];
  logic                lw_exp [4];

  initial begin
    //            rst run stl rdr rpc       iack idat    dack ddat chk ireq dreq fl pc        word      data
    tbl.push_back(mk(1, 0, 0, 0, 16'h0,    0, 64'h0,    0, '0, 0,  0, 0, 1, 16'h0,    64'h0,    '0));
    // zero-wait, no-load bundles at 0,1,2: flush 1,1,0,1,0,1,0
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h11,   0, '0, 1,  0, 0, 1, 16'h0,    64'h0,    '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h11,   0, '0, 1,  1, 0, 1, 16'h0,    64'h0,    '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h22,   0, '0, 1,  0, 0, 0, 16'h0,    64'h11,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h22,   0, '0, 1,  1, 0, 1, 16'h1,    64'h11,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h33,   0, '0, 1,  0, 0, 0, 16'h1,    64'h22,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h33,   0, '0, 1,  1, 0, 1, 16'h2,    64'h22,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h44,   0, '0, 1,  0, 0, 0, 16'h2,    64'h33,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h44,   0, '0, 1,  0, 0, 1, 16'h3,    64'h33,   '0));
    // restart from IDLE, then stall 4 cycles on pc=3
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h44,   0, '0, 1,  0, 0, 1, 16'h3,    64'h33,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h44,   0, '0, 1,  1, 0, 1, 16'h3,    64'h33,   '0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 1, 1, 0, 16'h0,  1, 64'h55,   0, '0, 1,  0, 0, 0, 16'h3,    64'h44,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h55,   0, '0, 1,  0, 0, 0, 16'h3,    64'h44,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h55,   0, '0, 1,  1, 0, 1, 16'h4,    64'h44,   '0));
    // load bundle at pc=5, dmem acks after 3 wait cycles
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, LW,       0, '0, 1,  0, 0, 0, 16'h4,    64'h55,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, LW,       0, '0, 1,  1, 0, 1, 16'h5,    64'h55,   '0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 0, 0, 16'h0,  1, LW,       0, '0, 1,  0, 1, 1, 16'h5,    LW,       '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, LW,       1, A5, 1,  0, 1, 1, 16'h5,    LW,       '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h66,   0, '0, 1,  0, 0, 0, 16'h5,    LW,       A5));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h66,   0, '0, 1,  1, 0, 1, 16'h6,    LW,       A5));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h77,   0, '0, 1,  0, 0, 0, 16'h6,    64'h66,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h77,   0, '0, 1,  1, 0, 1, 16'h7,    64'h66,   '0));
    // redirect during ISSUE of pc=7 squashes it
    tbl.push_back(mk(0, 1, 0, 1, 16'h20,   1, 64'h77,   0, '0, 1,  0, 0, 1, 16'h7,    64'h77,   '0));
    // redirect to 0x40 while imem ack is delayed 2 cycles
    tbl.push_back(mk(0, 1, 0, 1, 16'h40,   0, 64'hBAD,  0, '0, 1,  1, 0, 1, 16'h20,   64'h77,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    0, 64'hBAD,  0, '0, 1,  1, 0, 1, 16'h20,   64'h77,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'hBAD,  0, '0, 1,  1, 0, 1, 16'h20,   64'h77,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'h4040, 0, '0, 1,  1, 0, 1, 16'h40,   64'h77,   '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'hDEAD, 0, '0, 1,  0, 0, 0, 16'h40,   64'h4040, '0));
    // redirect in the same cycle as ack, target 0xFFFF, then wrap to 0
    tbl.push_back(mk(0, 1, 0, 1, 16'hFFFF, 1, 64'hDEAD, 0, '0, 1,  1, 0, 1, 16'h41,   64'h4040, '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'hF0,   0, '0, 1,  1, 0, 1, 16'hFFFF, 64'h4040, '0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 64'hF0,   0, '0, 1,  0, 0, 0, 16'hFFFF, 64'hF0,   '0));
    // run drops mid-transaction: bundle still issues, then IDLE; stray acks ignored
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    0, 64'h01,   0, '0, 1,  1, 0, 1, 16'h0,    64'hF0,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h01,   0, '0, 1,  1, 0, 1, 16'h0,    64'hF0,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h99,   0, '0, 1,  0, 0, 0, 16'h0,    64'h01,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h99,   1, A5, 1,  0, 0, 1, 16'h1,    64'h01,   '0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0,    1, 64'h99,   1, A5, 1,  0, 0, 1, 16'h1,    64'h01,   '0));

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].rst; run = tbl[i].run; stall = tbl[i].stall;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      imem_ack = tbl[i].iack; imem_rdata = tbl[i].idat;
      dmem_ack = tbl[i].dack; dmem_rdata = tbl[i].ddat;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("r%0d_imem_req", i),  LIT_W'(imem_req),  LIT_W'(tbl[i].ireq));
        check($sformatf("r%0d_dmem_req", i),  LIT_W'(dmem_req),  LIT_W'(tbl[i].dreq));
        check($sformatf("r%0d_flush", i),     LIT_W'(flush),     LIT_W'(tbl[i].flush));
        check($sformatf("r%0d_pc", i),        LIT_W'(pc),        LIT_W'(tbl[i].pc));
        check($sformatf("r%0d_imem_addr", i), LIT_W'(imem_addr), LIT_W'(tbl[i].pc));
        check($sformatf("r%0d_dmem_addr", i), LIT_W'(dmem_addr), LIT_W'(tbl[i].pc));
        check($sformatf("r%0d_word", i),      LIT_W'(word),      LIT_W'(tbl[i].word));
        check($sformatf("r%0d_data", i),      data,              tbl[i].data);
      end
    end

    // Load detection in each slot, plus an opcode one bit away from LOAD.
    lw_tbl[0] = 64'h0200_0000_0000_0000; lw_exp[0] = 1'b1;
    lw_tbl[1] = LW;                      lw_exp[1] = 1'b1;
    lw_tbl[2] = 64'h0000_0000_0002_0000; lw_exp[2] = 1'b1;
    lw_tbl[3] = 64'h0280_0000_0000_0000; lw_exp[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      reset = 1'b1; run = 1'b0; redirect = 1'b0; stall = 1'b0; dmem_ack = 1'b0;
      step();
      reset = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = lw_tbl[k];
      step();
      step();
      check($sformatf("load%0d_dmem_req", k), LIT_W'(dmem_req), LIT_W'(lw_exp[k]));
      check($sformatf("load%0d_flush", k),    LIT_W'(flush),    LIT_W'(lw_exp[k]));
    end

    // Still in DFETCH from the last load word above? No: index 3 issued. Re-enter DFETCH, then reset.
    reset = 1'b1; step();
    reset = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = LW;
    step();
    step();
    check("pre_reset_dmem_req", LIT_W'(dmem_req), LIT_W'(1'b1));
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rst_dmem_req", LIT_W'(dmem_req), LIT_W'(1'b0));
    check("rst_imem_req", LIT_W'(imem_req), LIT_W'(1'b0));
    check("rst_flush",    LIT_W'(flush),    LIT_W'(1'b1));
    check("rst_word",     LIT_W'(word),     LIT_W'(64'h0));
    check("rst_data",     data,             LIT_W'(0));
    check("rst_pc",       LIT_W'(pc),       LIT_W'(16'h0));
    step();
    check("rst_idle_hold", LIT_W'(imem_req), LIT_W'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
